param_inst_cache: RTL
=====================

PARAM_INST_CACHE -- requirements
Module: param_inst_cache

Interface
REQ-001 Parameter ADDR_W, default 32, CPU/memory address width in bits.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line; power of two, >=2.
REQ-003 Parameter SETS, default 8, number of direct-mapped lines; power of two, >=2.
REQ-004 Parameter NOP_INST, default 32'h0800_0000, instruction word driven on miss/stall.
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-007 cpu_req  input  1  fetch request valid this cycle.
REQ-008 cpu_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-009 flush  input  1  invalidate all lines.
REQ-010 inst  output  32  registered fetched instruction.
REQ-011 hit  output  1  registered; 1 when inst holds a valid cached word.
REQ-012 mem_req  output  1  line refill request, held until acknowledged.
REQ-013 mem_addr  output  ADDR_W  line-aligned refill address (offset bits zero).
REQ-014 mem_ack  input  1  refill data valid on mem_data this cycle.
REQ-015 mem_data  input  32*LINE_WORDS  full refill line; word 0 in bits [31:0].
REQ-016 hit_count, miss_count  output  16 each  lookup statistics counters.

Function
REQ-017 Address split SHALL be: OFF=log2(LINE_WORDS*4) low bits, IDX=log2(SETS) index bits above, TAG=ADDR_W-IDX-OFF remaining bits; word select = cpu_addr[OFF-1:2].
REQ-018 Each line SHALL store valid (1 bit), tag (TAG bits), data (32*LINE_WORDS bits).
REQ-019 FSM SHALL have two states: IDLE, REFILL.
REQ-020 IDLE, cpu_req=1, line valid and tag match: next cycle inst=selected word, hit=1, hit_count+1; one-cycle latency.
REQ-021 IDLE, cpu_req=1, miss: next cycle inst=NOP_INST, hit=0, miss_count+1, mem_req=1, mem_addr=line-aligned cpu_addr, state->REFILL.
REQ-022 IDLE, cpu_req=0: inst and hit SHALL hold previous values; counters unchanged.
REQ-023 REFILL: mem_req and mem_addr SHALL stay constant until the cycle mem_ack=1 is sampled.
REQ-024 REFILL with mem_ack=1: line at mem_addr index SHALL be written (data=mem_data, tag from mem_addr, valid=1); mem_req=0 next cycle; state->IDLE.
REQ-025 REFILL, cpu_req=1: inst=NOP_INST, hit=0; no new miss issued; counters unchanged.
REQ-026 Fetch in the cycle after refill completes SHALL hit if it targets the refilled line; no hit-under-refill/bypass.
REQ-027 flush=1 SHALL clear all valid bits on that edge; lookup in the same cycle SHALL be treated as a miss.
REQ-028 flush=1 and mem_ack=1 same cycle: flush wins; line not installed; FSM still returns to IDLE, mem_req=0.
REQ-029 flush=1 in REFILL without mem_ack: valid bits cleared, refill continues and installs normally when acked.
REQ-030 Counters SHALL wrap modulo 2^16.
REQ-031 mem_ack in IDLE SHALL be ignored.

Reset
REQ-032 Reset=1 SHALL take priority over all inputs including flush and mem_ack.
REQ-033 On reset: all valid=0, state=IDLE, inst=0, hit=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0.
REQ-034 Reset during REFILL SHALL abandon refill; a later mem_ack is ignored (REQ-031).
REQ-035 Tag/data arrays need not be reset.

Verification (defaults)
REQ-036 Reset, cpu_req=1 addr 0x0000_0040 -> next cycle hit=0, inst=0x0800_0000, mem_req=1, mem_addr=0x0000_0040, miss_count=1.
REQ-037 Continue: mem_ack=1, mem_data={W3,W2,W1,W0}; fetch 0x48 -> hit=1, inst=W2, hit_count=1.
REQ-038 Hold mem_ack=0 5 cycles in REFILL with cpu_req=1 -> mem_req/mem_addr stable, hit=0, inst=NOP, counters unchanged.
REQ-039 Line at 0x40 valid; fetch 0x440 (same index, tag differs) -> miss, mem_addr=0x440; after ack fetch 0x40 -> miss.
REQ-040 flush together with mem_ack -> refetch same address misses; Reset mid-REFILL -> mem_req=0 next cycle, later mem_ack installs nothing.
REQ-041 65536 hits -> hit_count wraps to 0.

Source files
------------

// File: rtl/param_inst_cache.sv
// Direct-mapped instruction cache: one-cycle registered hit, blocking single-line refill.
// Misses return NOP_INST and hold mem_req/mem_addr until mem_ack; fetches during refill return NOP_INST.
module param_inst_cache #(
  parameter int          ADDR_W     = 32,
  parameter int          LINE_WORDS = 4,
  parameter int          SETS       = 8,
  parameter logic [31:0] NOP_INST   = 32'h0800_0000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    flush,
  output logic [31:0]             inst,
  output logic                    hit,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [32*LINE_WORDS-1:0] mem_data,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
);

  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_W - IDX - OFF;
  localparam int WSEL = OFF - 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                       state;
  logic [SETS-1:0]              valid;
  logic [TAG-1:0]               tag_mem  [SETS];
  logic [LINE_WORDS-1:0][31:0]  data_mem [SETS];

  logic [IDX-1:0]  req_idx;
  logic [TAG-1:0]  req_tag;
  logic [WSEL-1:0] req_word;
  logic [IDX-1:0]  fill_idx;
  logic [TAG-1:0]  fill_tag;
  logic            lookup_hit;
  logic [1:0]      unused_byte_bits;

  assign req_idx          = cpu_addr[OFF+IDX-1:OFF];
  assign req_tag          = cpu_addr[ADDR_W-1:OFF+IDX];
  assign req_word         = cpu_addr[OFF-1:2];
  assign fill_idx         = mem_addr[OFF+IDX-1:OFF];
  assign fill_tag         = mem_addr[ADDR_W-1:OFF+IDX];
  assign unused_byte_bits = cpu_addr[1:0];

  // A flush in the lookup cycle forces a miss even if the line is resident.
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge Clk) begin
    if (!Reset && state == REFILL && mem_ack) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      valid      <= '0;
      inst       <= '0;
      hit        <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (lookup_hit) begin
              inst      <= data_mem[req_idx][req_word];
              hit       <= 1'b1;
              hit_count <= hit_count + 16'd1;
            end else begin
              inst       <= NOP_INST;
              hit        <= 1'b0;
              miss_count <= miss_count + 16'd1;
              mem_req    <= 1'b1;
              mem_addr   <= {cpu_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
              state      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (cpu_req) begin
            inst <= NOP_INST;
            hit  <= 1'b0;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!flush) valid[fill_idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Flush overrides any install on the same edge.
      if (flush) valid <= '0;
    end
  end

endmodule
